// File: rtl/chronologic_pkg.sv
// Shared types and helpers for the chronologic pulse-duration checker.
package chronologic_pkg;

  typedef enum logic [1:0] {
    WAIT_LOW,
    IDLE,
    RUN,
    OVERRUN
  } chron_state_e;

  typedef enum logic [1:0] {
    NONE,
    PASS,
    SHORT,
    LONG
  } chron_verdict_e;

  // Width able to hold run lengths 0 .. max+1 (max+1 marks an overrun).
  function automatic int unsigned len_width(input int unsigned max);
    return $clog2(max + 2);
  endfunction

endpackage

// File: rtl/chronologic_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module chronologic_sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/chronologic.sv
// Measures each high run of sig_i and issues a registered pass/short/long
// verdict pulse, the judged length, and saturating pass/fail tallies.
module chronologic
  import chronologic_pkg::*;
#(
  parameter int unsigned MIN_HIGH = 2,
  parameter int unsigned MAX_HIGH = 6,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              sig_i,
  input  logic                              cnt_clr_i,
  output logic                              pass_o,
  output logic                              fail_short_o,
  output logic                              fail_long_o,
  output logic [len_width(MAX_HIGH)-1:0]    last_len_o,
  output logic                              busy_o,
  output logic [CNT_W-1:0]                  pass_count_o,
  output logic [CNT_W-1:0]                  fail_count_o
);

  localparam int unsigned LW = len_width(MAX_HIGH);
  localparam logic [LW-1:0] MIN_L  = LW'(MIN_HIGH);
  localparam logic [LW-1:0] MAX_L  = LW'(MAX_HIGH);
  localparam logic [LW-1:0] OVER_L = LW'(MAX_HIGH + 1);

  generate
    if (MIN_HIGH < 1 || MAX_HIGH < MIN_HIGH) begin : g_bad_params
      $fatal(1, "chronologic: illegal MIN_HIGH/MAX_HIGH");
    end
  endgenerate

  chron_state_e   state_q, state_d;
  chron_verdict_e verdict_d;
  logic [LW-1:0]  run_cnt_q, run_cnt_d;
  logic [LW-1:0]  last_len_d;
  logic           busy_d;

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    last_len_d = last_len_o;
    verdict_d  = NONE;
    unique case (state_q)
      WAIT_LOW: begin
        if (!sig_i) state_d = IDLE;
      end
      IDLE: begin
        if (sig_i) begin
          state_d   = RUN;
          run_cnt_d = LW'(1);
        end
      end
      RUN: begin
        if (sig_i) begin
          if (run_cnt_q < MAX_L) begin
            run_cnt_d = run_cnt_q + 1'b1;
          end else begin
            verdict_d  = LONG;
            last_len_d = OVER_L;
            state_d    = OVERRUN;
            run_cnt_d  = '0;
          end
        end else begin
          last_len_d = run_cnt_q;
          verdict_d  = (run_cnt_q >= MIN_L) ? PASS : SHORT;
          state_d    = IDLE;
          run_cnt_d  = '0;
        end
      end
      OVERRUN: begin
        if (!sig_i) state_d = IDLE;
      end
      default: state_d = WAIT_LOW;
    endcase
    busy_d = (state_d == RUN) || (state_d == OVERRUN);
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q      <= WAIT_LOW;
      run_cnt_q    <= '0;
      last_len_o   <= '0;
      busy_o       <= 1'b0;
      pass_o       <= 1'b0;
      fail_short_o <= 1'b0;
      fail_long_o  <= 1'b0;
    end else begin
      state_q      <= state_d;
      run_cnt_q    <= run_cnt_d;
      last_len_o   <= last_len_d;
      busy_o       <= busy_d;
      pass_o       <= (verdict_d == PASS);
      fail_short_o <= (verdict_d == SHORT);
      fail_long_o  <= (verdict_d == LONG);
    end
  end

  // Tallies count the verdict being registered this edge, so they move with the pulse.
  chronologic_sat_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (verdict_d == PASS),
    .clr   (cnt_clr_i),
    .count (pass_count_o)
  );

  chronologic_sat_cnt #(.W(CNT_W)) u_fail_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   ((verdict_d == SHORT) || (verdict_d == LONG)),
    .clr   (cnt_clr_i),
    .count (fail_count_o)
  );

endmodule

// File: tb/tb_chronologic.sv
// Directed vector bench for chronologic: default instance plus a CNT_W=2 instance.
module tb_chronologic;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sig = 1'b0, clr = 1'b0;
  logic sig_s = 1'b0, clr_s = 1'b0;

  logic        pass, fshort, flong, busy;
  logic [2:0]  len;
  logic [15:0] pc, fc;
  logic        pass_s, fshort_s, flong_s, busy_s;
  logic [2:0]  len_s;
  logic [1:0]  pc_s, fc_s;

  int checks = 0;
  int failures = 0;

  chronologic #(.MIN_HIGH(2), .MAX_HIGH(6), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .sig_i(sig), .cnt_clr_i(clr),
    .pass_o(pass), .fail_short_o(fshort), .fail_long_o(flong),
    .last_len_o(len), .busy_o(busy), .pass_count_o(pc), .fail_count_o(fc)
  );

  chronologic #(.MIN_HIGH(2), .MAX_HIGH(6), .CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .sig_i(sig_s), .cnt_clr_i(clr_s),
    .pass_o(pass_s), .fail_short_o(fshort_s), .fail_long_o(flong_s),
    .last_len_o(len_s), .busy_o(busy_s), .pass_count_o(pc_s), .fail_count_o(fc_s)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct packed {
    logic        s;
    logic        c;
    logic        p;
    logic        sh;
    logic        lg;
    logic [2:0]  ln;
    logic        b;
    logic [15:0] pcnt;
    logic [15:0] fcnt;
  } vec_t;

  function automatic logic [38:0] outs();
    return {pass, fshort, flong, len, busy, pc, fc};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic s, input logic c);
    @(negedge clk);
    sig = s;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_s(input logic s, input logic c);
    @(negedge clk);
    sig_s = s;
    clr_s = c;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[25];

  initial begin
    //          s   c   p   sh  lg  len   b   pc  fc
    vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd0,1'b0,16'd0,16'd0};
    vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,16'd0,16'd0};
    vecs[2]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd0,1'b1,16'd0,16'd0};
    vecs[3]  = '{1'b0,1'b0,1'b1,1'b0,1'b0,3'd2,1'b0,16'd1,16'd0};
    vecs[4]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd2,1'b1,16'd1,16'd0};
    vecs[5]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd2,1'b1,16'd1,16'd0};
    vecs[6]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd2,1'b1,16'd1,16'd0};
    vecs[7]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd2,1'b1,16'd1,16'd0};
    vecs[8]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd2,1'b1,16'd1,16'd0};
    vecs[9]  = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd2,1'b1,16'd1,16'd0};
    vecs[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,3'd6,1'b0,16'd2,16'd0};
    vecs[11] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd6,1'b0,16'd2,16'd0};
    vecs[12] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd6,1'b1,16'd2,16'd0};
    vecs[13] = '{1'b0,1'b0,1'b0,1'b1,1'b0,3'd1,1'b0,16'd2,16'd1};
    vecs[14] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd1,1'b1,16'd2,16'd1};
    vecs[15] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd1,1'b1,16'd2,16'd1};
    vecs[16] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd1,1'b1,16'd2,16'd1};
    vecs[17] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd1,1'b1,16'd2,16'd1};
    vecs[18] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd1,1'b1,16'd2,16'd1};
    vecs[19] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd1,1'b1,16'd2,16'd1};
    vecs[20] = '{1'b1,1'b0,1'b0,1'b0,1'b1,3'd7,1'b1,16'd2,16'd2};
    vecs[21] = '{1'b1,1'b0,1'b0,1'b0,1'b0,3'd7,1'b1,16'd2,16'd2};
    vecs[22] = '{1'b0,1'b0,1'b0,1'b0,1'b0,3'd7,1'b0,16'd2,16'd2};
    vecs[23] = '{1'b1,1'b1,1'b0,1'b0,1'b0,3'd7,1'b1,16'd0,16'd0};
    vecs[24] = '{1'b0,1'b0,1'b0,1'b1,1'b0,3'd1,1'b0,16'd0,16'd1};

    // Reset state
    @(posedge clk);
    @(posedge clk);
    #1;
    check("reset_state", 64'(outs()), 64'd0);
    @(negedge clk);
    rst_n = 1'b0;

    for (int i = 0; i < 25; i++) begin
      cyc(vecs[i].s, vecs[i].c);
      check($sformatf("vec%0d", i), 64'(outs()),
            64'({vecs[i].p, vecs[i].sh, vecs[i].lg, vecs[i].ln, vecs[i].b, vecs[i].pcnt, vecs[i].fcnt}));
    end

    // Signal already high at reset release is never judged
    @(negedge clk);
    rst_n = 1'b1;
    sig = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 1'b0);
      check($sformatf("hi_at_release%0d", i), 64'({pass, fshort, flong, busy, len}), 64'd0);
    end
    cyc(1'b0, 1'b0);
    check("hi_at_release_low", 64'({pass, fshort, flong, busy}), 64'd0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("second_run_busy", 64'(busy), 64'd1);
    cyc(1'b0, 1'b0);
    check("second_run_pass", 64'({pass, fshort, flong, len, pc, fc}),
          64'({1'b1, 1'b0, 1'b0, 3'd2, 16'd1, 16'd0}));

    // Asynchronous reset mid-run discards the run
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    check("midrun_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b1;
    #1;
    check("midrun_async_reset", 64'(outs()), 64'd0);
    @(negedge clk);
    sig = 1'b0;
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    check("after_midrun_reset", 64'(outs()), 64'd0);

    // Tally saturation on the CNT_W=2 instance
    for (int k = 1; k <= 5; k++) begin
      cyc_s(1'b1, 1'b0);
      cyc_s(1'b1, 1'b0);
      cyc_s(1'b0, 1'b0);
      check($sformatf("sat_run%0d", k), 64'({pass_s, pc_s}),
            64'({1'b1, (k >= 3) ? 2'd3 : 2'(k)}));
    end
    cyc_s(1'b1, 1'b0);
    cyc_s(1'b1, 1'b0);
    cyc_s(1'b0, 1'b1);
    check("clr_with_verdict", 64'({pass_s, len_s, pc_s, fc_s}), 64'({1'b1, 3'd2, 2'd0, 2'd0}));
    cyc_s(1'b0, 1'b0);
    check("clr_after", 64'({pass_s, pc_s}), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/chronologic.md
# chronologic

Pulse-duration checker that monitors a single-bit level signal. It measures every high run in clock cycles and flags runs shorter than `MIN_HIGH` or longer than `MAX_HIGH`. It sits beside the signal's producer as a synthesizable protocol monitor. It reports one-cycle verdict pulses, the last run length and saturating pass/fail tallies to status/debug logic.

## Interface
- `MIN_HIGH`, default 2: minimum legal high run length in cycles (≥1).
- `MAX_HIGH`, default 6: maximum legal high run length in cycles (≥ `MIN_HIGH`).
- `CNT_W`, default 16: width of the pass/fail tally counters.
- `clk`, input, 1: clock; all sampling is on the rising edge.
- `rst_n`, input, 1: reset rst_n, asynchronous, active-high; clock clk.
- `sig_i`, input, 1: monitored level signal, sampled on each `clk` rising edge.
- `cnt_clr_i`, input, 1: synchronous clear of both tally counters.
- `pass_o`, output, 1: one-cycle pulse; a run ended with length in [`MIN_HIGH`, `MAX_HIGH`].
- `fail_short_o`, output, 1: one-cycle pulse; a run ended with length < `MIN_HIGH`.
- `fail_long_o`, output, 1: one-cycle pulse; a run reached `MAX_HIGH`+1 high samples.
- `last_len_o`, output, `$clog2(MAX_HIGH+2)`: length of the last judged run; equals `MAX_HIGH`+1 for an overrun.
- `busy_o`, output, 1: a run is in progress (state RUN or OVERRUN).
- `pass_count_o`, output, `CNT_W`: saturating count of `pass_o` events.
- `fail_count_o`, output, `CNT_W`: saturating count of `fail_short_o` plus `fail_long_o` events.

## Operation
- FSM states: WAIT_LOW, IDLE, RUN, OVERRUN. The reset state is WAIT_LOW.
- WAIT_LOW: `sig_i`=0 moves to IDLE. A signal already high at reset release is never judged.
- IDLE: `sig_i`=1 moves to RUN with run_cnt=1. This is the rising edge: current sample high, previous sample low.
- RUN, `sig_i`=1 and run_cnt<`MAX_HIGH`: run_cnt increments.
- RUN, `sig_i`=1 and run_cnt=`MAX_HIGH`: pulse `fail_long_o`, set `last_len_o`=`MAX_HIGH`+1, move to OVERRUN.
- RUN, `sig_i`=0: set `last_len_o`=run_cnt.
  - run_cnt ≥ `MIN_HIGH`: pulse `pass_o`.
  - Otherwise: pulse `fail_short_o`.
  - In both cases move to IDLE.
- OVERRUN: `sig_i`=0 moves to IDLE with no verdict. A long run yields exactly one verdict.
- At most one of `pass_o`, `fail_short_o`, `fail_long_o` is high in any cycle.
- Tallies saturate at all-ones and do not wrap.
- `cnt_clr_i` has priority over a same-cycle increment. It does not affect the FSM or `last_len_o`.
- Illegal parameters are an elaboration-time fatal: `MIN_HIGH`<1 or `MAX_HIGH`<`MIN_HIGH`.

## Timing
- All outputs are registered.
- A verdict is computed from the sample taken at clock edge k. The pulse is high from edge k until edge k+1.
- A short or legal run is judged at the first low sample after the run.
- A long run is judged at its (`MAX_HIGH`+1)th high sample, not at its fall.
- Back-to-back runs: a low sample followed by a high sample starts a new run immediately. A single low cycle between runs is sufficient.
- Reset values: FSM=WAIT_LOW, run_cnt=0, all pulse outputs 0, `last_len_o`=0, `busy_o`=0, both tallies 0.
- Reset asserted mid-run: the run is discarded with no verdict, and state returns to WAIT_LOW immediately (asynchronous).

## Structure
- Package `chronologic_pkg` holds:
  - the FSM state enum `chron_state_e` (WAIT_LOW, IDLE, RUN, OVERRUN);
  - the verdict enum `chron_verdict_e` (NONE, PASS, SHORT, LONG);
  - a `len_width(max)` function returning `$clog2(max+2)`.
- Sub-module `chronologic_sat_cnt` (parameter `W`; inputs inc and clr) is instantiated twice, once per tally.
- The top level contains the FSM, the run counter and the output registers.

## Test plan
- Reset released with `sig_i`=0; `sig_i` high for 2 samples, then low → `pass_o` pulses once at the low sample; `last_len_o`=2; `pass_count_o`=1.
- `sig_i` high for 6 samples, then low → `pass_o` at the fall; `last_len_o`=6; no fail pulse.
- `sig_i` high for 1 sample, then low → `fail_short_o` at the low sample; `last_len_o`=1; `fail_count_o` increments.
- `sig_i` high for 7 samples, then low → `fail_long_o` at the 7th high sample; `last_len_o`=7; no verdict at the fall; `busy_o` stays high until the low sample.
- `sig_i` high at reset release for 3 samples, then a 2-sample run → the first run is ignored; the second run gives `pass_o`. Separately, assert `rst_n` mid-run → no verdict and all outputs 0.
- With `CNT_W`=2, produce 5 legal runs → `pass_count_o` saturates at 3. Pulse `cnt_clr_i` together with a verdict → count reads 0.
